// File: rtl/rs_pkg.sv
// Shared constants and reservation-station entry layout for rs_wakeup_select.
package rs_pkg;

    localparam int RS_ENTRIES = 4;
    localparam int RS_DATA_W  = 32;
    localparam int RS_TAG_W   = 3;
    localparam int RS_OP_W    = 4;
    localparam int RS_CDB_N   = 2;

    // One reservation-station slot; widths follow the package defaults.
    typedef struct packed {
        logic                 busy;
        logic [RS_OP_W-1:0]   op;
        logic [RS_DATA_W-1:0] vj;
        logic [RS_DATA_W-1:0] vk;
        logic                 qj_pend;
        logic [RS_TAG_W-1:0]  qj;
        logic                 qk_pend;
        logic [RS_TAG_W-1:0]  qk;
        logic [RS_TAG_W-1:0]  dest;
    } rs_entry_t;

endpackage

// File: rtl/rs_wakeup_select_if.sv
// Dispatch, CDB broadcast and issue signals of the reservation station.
interface rs_wakeup_select_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3,
    parameter int OP_W   = 4,
    parameter int CDB_N  = 2
);
    logic                    disp_valid;
    logic                    disp_ready;
    logic [OP_W-1:0]         disp_op;
    logic [TAG_W-1:0]        disp_dest;
    logic [DATA_W-1:0]       disp_vj;
    logic [DATA_W-1:0]       disp_vk;
    logic                    disp_qj_pend;
    logic                    disp_qk_pend;
    logic [TAG_W-1:0]        disp_qj;
    logic [TAG_W-1:0]        disp_qk;

    logic [CDB_N-1:0]        cdb_valid;
    logic [CDB_N*TAG_W-1:0]  cdb_tag;
    logic [CDB_N*DATA_W-1:0] cdb_data;

    logic                    issue_valid;
    logic                    issue_ready;
    logic [OP_W-1:0]         issue_op;
    logic [DATA_W-1:0]       issue_vj;
    logic [DATA_W-1:0]       issue_vk;
    logic [TAG_W-1:0]        issue_dest;

    modport master (
        output disp_valid, disp_op, disp_dest, disp_vj, disp_vk,
               disp_qj_pend, disp_qk_pend, disp_qj, disp_qk,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  disp_ready, issue_valid, issue_op, issue_vj, issue_vk, issue_dest
    );

    modport slave (
        input  disp_valid, disp_op, disp_dest, disp_vj, disp_vk,
               disp_qj_pend, disp_qk_pend, disp_qj, disp_qk,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output disp_ready, issue_valid, issue_op, issue_vj, issue_vk, issue_dest
    );

endinterface

// File: rtl/rs_select.sv
// Ready vector to one-hot grant. RS_AGE_SELECT_EN: oldest ready entry via age matrix;
// otherwise lowest-index ready entry with no state.
module rs_select #(
    parameter int ENTRIES = 4
) (
`ifdef RS_AGE_SELECT_EN
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRIES-1:0] alloc,
`endif
    input  logic [ENTRIES-1:0] ready,
    output logic [ENTRIES-1:0] grant
);

`ifdef RS_AGE_SELECT_EN
    // older_q[j][i] set means entry j was dispatched before entry i.
    logic [ENTRIES-1:0] older_q [ENTRIES];
    logic [ENTRIES-1:0] beaten;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < ENTRIES; j++) begin
                older_q[j] <= '0;
            end
        end else begin
            for (int k = 0; k < ENTRIES; k++) begin
                if (alloc[k]) begin
                    for (int j = 0; j < ENTRIES; j++) begin
                        older_q[k][j] <= 1'b0;
                        older_q[j][k] <= (j != k);
                    end
                end
            end
        end
    end

    always_comb begin
        beaten = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (ready[j] && older_q[j][i]) begin
                    beaten[i] = 1'b1;
                end
            end
        end
        grant = ready & ~beaten;
    end
`else
    assign grant = ready & (~ready + ENTRIES'(1));
`endif

endmodule

// File: rtl/rs_wakeup_select.sv
// Reservation station with CDB wakeup and single-issue select.
// Optional oldest-first selection under RS_AGE_SELECT_EN.
module rs_wakeup_select
    import rs_pkg::*;
#(
    parameter int ENTRIES = RS_ENTRIES,
    parameter int DATA_W  = RS_DATA_W,
    parameter int TAG_W   = RS_TAG_W,
    parameter int OP_W    = RS_OP_W,
    parameter int CDB_N   = RS_CDB_N
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    rs_wakeup_select_if.slave            bus,
    output logic [$clog2(ENTRIES+1)-1:0] count
);

    localparam int CNT_W = $clog2(ENTRIES+1);

    rs_entry_t          ent_q [ENTRIES];
    rs_entry_t          ent_d [ENTRIES];
    rs_entry_t          new_ent;
    logic [ENTRIES-1:0] busy;
    logic [ENTRIES-1:0] rdy;
    logic [ENTRIES-1:0] alloc;
    logic [ENTRIES-1:0] sel_grant;
    logic [ENTRIES-1:0] grant;
    logic [ENTRIES-1:0] hold_grant_q;
    logic               hold_q;
    logic               hold_keep;
    logic               disp_fire;
    logic               issue_fire;
    logic [DATA_W:0]    snoop_j [ENTRIES];
    logic [DATA_W:0]    snoop_k [ENTRIES];
    logic [DATA_W:0]    disp_snoop_j;
    logic [DATA_W:0]    disp_snoop_k;
    logic [OP_W-1:0]    iss_op;
    logic [DATA_W-1:0]  iss_vj;
    logic [DATA_W-1:0]  iss_vk;
    logic [TAG_W-1:0]   iss_dest;

    // MSB is the hit flag; scanning downward lets the lowest channel win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]        tag,
        input logic [CDB_N-1:0]        vld,
        input logic [CDB_N*TAG_W-1:0]  tags,
        input logic [CDB_N*DATA_W-1:0] data
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, data[c*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    always_comb begin
        count = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            busy[i] = ent_q[i].busy;
            rdy[i]  = ent_q[i].busy && !ent_q[i].qj_pend && !ent_q[i].qk_pend;
            count   = count + CNT_W'(ent_q[i].busy);
        end
    end

    assign bus.disp_ready  = (int'(count) < ENTRIES) && !flush;
    assign disp_fire       = bus.disp_valid && bus.disp_ready;
    assign alloc           = ~busy & (busy + ENTRIES'(1));
    assign bus.issue_valid = |rdy;
    assign issue_fire      = bus.issue_valid && bus.issue_ready;

    rs_select #(.ENTRIES(ENTRIES)) u_select (
`ifdef RS_AGE_SELECT_EN
        .clk   (clk),
        .rst   (rst),
        .alloc (alloc & {ENTRIES{disp_fire}}),
`endif
        .ready (rdy),
        .grant (sel_grant)
    );

    // A stalled issue keeps its entry until the FU accepts it.
    assign hold_keep = hold_q && |(hold_grant_q & rdy);
    assign grant     = hold_keep ? hold_grant_q : sel_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q       <= 1'b0;
            hold_grant_q <= '0;
        end else begin
            hold_q       <= bus.issue_valid && !bus.issue_ready && !flush;
            hold_grant_q <= grant;
        end
    end

    always_comb begin
        iss_op   = '0;
        iss_vj   = '0;
        iss_vk   = '0;
        iss_dest = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant[i]) begin
                iss_op   = iss_op   | ent_q[i].op;
                iss_vj   = iss_vj   | ent_q[i].vj;
                iss_vk   = iss_vk   | ent_q[i].vk;
                iss_dest = iss_dest | ent_q[i].dest;
            end
        end
    end

    assign bus.issue_op   = iss_op;
    assign bus.issue_vj   = iss_vj;
    assign bus.issue_vk   = iss_vk;
    assign bus.issue_dest = iss_dest;

    always_comb begin
        disp_snoop_j = cdb_lookup(bus.disp_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        disp_snoop_k = cdb_lookup(bus.disp_qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

        new_ent.busy    = 1'b1;
        new_ent.op      = bus.disp_op;
        new_ent.dest    = bus.disp_dest;
        new_ent.qj      = bus.disp_qj;
        new_ent.qk      = bus.disp_qk;
        new_ent.qj_pend = bus.disp_qj_pend && !disp_snoop_j[DATA_W];
        new_ent.qk_pend = bus.disp_qk_pend && !disp_snoop_k[DATA_W];
        new_ent.vj      = (bus.disp_qj_pend && disp_snoop_j[DATA_W]) ?
                          disp_snoop_j[DATA_W-1:0] : bus.disp_vj;
        new_ent.vk      = (bus.disp_qk_pend && disp_snoop_k[DATA_W]) ?
                          disp_snoop_k[DATA_W-1:0] : bus.disp_vk;
    end

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < ENTRIES; i++) begin
            snoop_j[i] = cdb_lookup(ent_q[i].qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            snoop_k[i] = cdb_lookup(ent_q[i].qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

            if (issue_fire && grant[i]) begin
                ent_d[i].busy = 1'b0;
            end
            if (ent_q[i].busy && ent_q[i].qj_pend && snoop_j[i][DATA_W]) begin
                ent_d[i].vj      = snoop_j[i][DATA_W-1:0];
                ent_d[i].qj_pend = 1'b0;
            end
            if (ent_q[i].busy && ent_q[i].qk_pend && snoop_k[i][DATA_W]) begin
                ent_d[i].vk      = snoop_k[i][DATA_W-1:0];
                ent_d[i].qk_pend = 1'b0;
            end
            if (disp_fire && alloc[i]) begin
                ent_d[i] = new_ent;
            end
            if (flush) begin
                ent_d[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_wakeup_select.sv
// Scoreboard bench for rs_wakeup_select: expected issues queued at stimulus time, popped on handshake.
module tb_rs_wakeup_select;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] count;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [2:0]  dest;
    } exp_t;

    exp_t sb[$];

    rs_wakeup_select_if #(.DATA_W(32), .TAG_W(3), .OP_W(4), .CDB_N(2)) bus ();

    rs_wakeup_select #(
        .ENTRIES (4),
        .DATA_W  (32),
        .TAG_W   (3),
        .OP_W    (4),
        .CDB_N   (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp_set(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [2:0] dest, input logic qjp, input logic [2:0] qj,
                            input logic qkp, input logic [2:0] qk);
        bus.disp_valid   = 1'b1;
        bus.disp_op      = op;
        bus.disp_vj      = vj;
        bus.disp_vk      = vk;
        bus.disp_dest    = dest;
        bus.disp_qj_pend = qjp;
        bus.disp_qj      = qj;
        bus.disp_qk_pend = qkp;
        bus.disp_qk      = qk;
    endtask

    task automatic expect_issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                input logic [2:0] dest);
        exp_t e;
        e.op   = op;
        e.vj   = vj;
        e.vk   = vk;
        e.dest = dest;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.issue_valid && bus.issue_ready) begin
            if (sb.size() == 0) begin
                chk("iss_unexpected", bus.issue_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("iss_op",   bus.issue_op,   e.op);
                chk("iss_vj",   bus.issue_vj,   e.vj);
                chk("iss_vk",   bus.issue_vk,   e.vk);
                chk("iss_dest", bus.issue_dest, e.dest);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        flush = 1'b0;
        bus.disp_valid   = 1'b0;
        bus.disp_op      = '0;
        bus.disp_vj      = '0;
        bus.disp_vk      = '0;
        bus.disp_dest    = '0;
        bus.disp_qj_pend = 1'b0;
        bus.disp_qj      = '0;
        bus.disp_qk_pend = 1'b0;
        bus.disp_qk      = '0;
        bus.cdb_valid    = '0;
        bus.cdb_tag      = '0;
        bus.cdb_data     = '0;
        bus.issue_ready  = 1'b0;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_iv", bus.issue_valid, 0);
        chk("rst_dr", bus.disp_ready, 1);
        chk("rst_ivj", bus.issue_vj, 0);
        tick();
        rst = 1'b0;
        tick();

        // Simple ready dispatch, issue one cycle later.
        disp_set(4'd3, 32'd5, 32'd7, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        bus.disp_valid = 1'b0;
        @(negedge clk);
        chk("t1_count1", count, 1);
        chk("t1_iv", bus.issue_valid, 1);
        chk("t1_vj", bus.issue_vj, 5);
        chk("t1_vk", bus.issue_vk, 7);
        tick();
        expect_issue(4'd3, 32'd5, 32'd7, 3'd1);
        bus.issue_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t1_count0", count, 0);
        chk("t1_iv0", bus.issue_valid, 0);

        // Pending qj woken by CDB channel 1 two cycles after dispatch.
        tick();
        disp_set(4'd2, 32'd0, 32'd9, 3'd2, 1'b1, 3'd2, 1'b0, 3'd0);
        tick();
        bus.disp_valid = 1'b0;
        @(negedge clk);
        chk("t2_pend_a", bus.issue_valid, 0);
        tick();
        @(negedge clk);
        chk("t2_pend_b", bus.issue_valid, 0);
        tick();
        bus.cdb_valid = 2'b10;
        bus.cdb_tag   = {3'd2, 3'd3};
        bus.cdb_data  = {32'hAA, 32'h11};
        @(negedge clk);
        chk("t2_bcast_cyc", bus.issue_valid, 0);
        tick();
        bus.cdb_valid = 2'b00;
        expect_issue(4'd2, 32'hAA, 32'd9, 3'd2);
        @(negedge clk);
        chk("t2_wake_lat", bus.issue_valid, 1);
        tick();
        @(negedge clk);
        chk("t2_count0", count, 0);

        // Capture at dispatch; both channels match, channel 0 wins.
        tick();
        bus.issue_ready = 1'b0;
        disp_set(4'd5, 32'd1, 32'd0, 3'd3, 1'b0, 3'd0, 1'b1, 3'd4);
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {3'd4, 3'd4};
        bus.cdb_data  = {32'h66, 32'h55};
        tick();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 2'b00;
        @(negedge clk);
        chk("t3_iv", bus.issue_valid, 1);
        chk("t3_vk", bus.issue_vk, 32'h55);
        tick();
        expect_issue(4'd5, 32'd1, 32'h55, 3'd3);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        @(negedge clk);
        chk("t3_count0", count, 0);

        // Full station: dispatch blocked even with a same-cycle issue.
        tick();
        for (int k = 0; k < 4; k++) begin
            disp_set(4'd6, 32'd10 + 32'(k), 32'(k), 3'(k), 1'b0, 3'd0, 1'b0, 3'd0);
            tick();
        end
        bus.disp_valid = 1'b0;
        @(negedge clk);
        chk("t4_count4", count, 4);
        chk("t4_dr0", bus.disp_ready, 0);
        tick();
        disp_set(4'd7, 32'd99, 32'd0, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0);
        bus.issue_ready = 1'b1;
        expect_issue(4'd6, 32'd10, 32'd0, 3'd0);
        @(negedge clk);
        chk("t4_dr_issue", bus.disp_ready, 0);
        tick();
        bus.disp_valid  = 1'b0;
        bus.issue_ready = 1'b0;
        @(negedge clk);
        chk("t4_no_accept", count, 3);
        tick();
        for (int k = 1; k < 4; k++) begin
            expect_issue(4'd6, 32'd10 + 32'(k), 32'(k), 3'(k));
        end
        bus.issue_ready = 1'b1;
        repeat (3) tick();
        bus.issue_ready = 1'b0;
        @(negedge clk);
        chk("t4_drained", count, 0);

        // Slot 2 dispatched before slot 0, both woken by the same broadcast.
        tick();
        disp_set(4'd1, 32'h21, 32'd0, 3'd4, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        disp_set(4'd1, 32'd0, 32'h31, 3'd5, 1'b1, 3'd7, 1'b0, 3'd0);
        tick();
        disp_set(4'd8, 32'd0, 32'hC2, 3'd6, 1'b1, 3'd6, 1'b0, 3'd0);
        tick();
        bus.disp_valid = 1'b0;
        expect_issue(4'd1, 32'h21, 32'd0, 3'd4);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        disp_set(4'd9, 32'd0, 32'hD0, 3'd7, 1'b1, 3'd6, 1'b0, 3'd0);
        tick();
        bus.disp_valid = 1'b0;
        @(negedge clk);
        chk("t5_count3", count, 3);
        chk("t5_iv0", bus.issue_valid, 0);
        tick();
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {3'd0, 3'd6};
        bus.cdb_data  = {32'h0, 32'h60};
        tick();
        bus.cdb_valid = 2'b00;
`ifdef RS_AGE_SELECT_EN
        expect_issue(4'd8, 32'h60, 32'hC2, 3'd6);
        expect_issue(4'd9, 32'h60, 32'hD0, 3'd7);
`else
        expect_issue(4'd9, 32'h60, 32'hD0, 3'd7);
        expect_issue(4'd8, 32'h60, 32'hC2, 3'd6);
`endif
        bus.issue_ready = 1'b1;
        @(negedge clk);
        chk("t5_both_rdy", bus.issue_valid, 1);
        tick();
        tick();
        bus.cdb_valid = 2'b10;
        bus.cdb_tag   = {3'd7, 3'd0};
        bus.cdb_data  = {32'h70, 32'h0};
        expect_issue(4'd1, 32'h70, 32'h31, 3'd5);
        tick();
        bus.cdb_valid = 2'b00;
        tick();
        bus.issue_ready = 1'b0;
        @(negedge clk);
        chk("t5_count0", count, 0);

        // Flush with three busy entries and a dispatch attempt.
        tick();
        for (int k = 0; k < 3; k++) begin
            disp_set(4'd2, 32'h40 + 32'(k), 32'd0, 3'(k), 1'b0, 3'd0, 1'b0, 3'd0);
            tick();
        end
        disp_set(4'd2, 32'h50, 32'd0, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0);
        flush = 1'b1;
        @(negedge clk);
        chk("t6_dr_flush", bus.disp_ready, 0);
        chk("t6_iv_flush", bus.issue_valid, 1);
        tick();
        flush = 1'b0;
        bus.disp_valid = 1'b0;
        @(negedge clk);
        chk("t6_count0", count, 0);
        chk("t6_iv0", bus.issue_valid, 0);

        // Reset asserted between edges discards entries at once.
        tick();
        disp_set(4'd3, 32'h61, 32'd0, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        disp_set(4'd3, 32'h62, 32'd0, 3'd2, 1'b1, 3'd5, 1'b0, 3'd0);
        tick();
        bus.disp_valid = 1'b0;
        @(negedge clk);
        chk("t7_count2", count, 2);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_count", count, 0);
        chk("t7_rst_iv", bus.issue_valid, 0);
        chk("t7_rst_ivj", bus.issue_vj, 0);
        chk("t7_rst_dr", bus.disp_ready, 1);
        tick();
        rst = 1'b0;
        disp_set(4'd4, 32'h77, 32'h88, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        bus.disp_valid = 1'b0;
        expect_issue(4'd4, 32'h77, 32'h88, 3'd2);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        @(negedge clk);
        chk("t7_count0", count, 0);

        // Dispatch and issue in the same cycle leave count unchanged.
        tick();
        disp_set(4'd3, 32'hA1, 32'd0, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        disp_set(4'd3, 32'hB2, 32'd0, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0);
        expect_issue(4'd3, 32'hA1, 32'd0, 3'd1);
        bus.issue_ready = 1'b1;
        tick();
        bus.disp_valid  = 1'b0;
        bus.issue_ready = 1'b0;
        @(negedge clk);
        chk("t8_count1", count, 1);
        tick();
        expect_issue(4'd3, 32'hB2, 32'd0, 3'd2);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        @(negedge clk);
        chk("t8_count0", count, 0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
